// File: rtl/zfifo_sync_ctrl_pkg.sv
// Shared FIFO helpers: pointer width and depth legality, reused by the sync and async FIFOs.
package zfifo_sync_ctrl_pkg;

  // One extra pointer bit separates full from empty once the address wraps.
  function automatic int ptrWidth(input int log2Depth);
    return log2Depth + 1;
  endfunction

  function automatic bit depthOk(input int depth, input int log2Depth);
    return (depth >= 2) && (depth == (1 << log2Depth));
  endfunction

endpackage

// File: rtl/zfifo_sync_ctrl_dualport.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module zfifo_dualport
  import zfifo_sync_ctrl_pkg::*;
#(
  parameter int depth      = 64,
  parameter int log2_depth = 6,
  parameter int width      = 8
) (
  input  logic                  iClk,
  input  logic                  iWrEn,
  input  logic [log2_depth-1:0] iWrAddr,
  input  logic [width-1:0]      iWrData,
  input  logic                  iRdEn,
  input  logic [log2_depth-1:0] iRdAddr,
  output logic [width-1:0]      oRdData
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge iClk) begin
    if (iWrEn) mem[iWrAddr] <= iWrData;
    if (iRdEn) oRdData <= mem[iRdAddr];
  end

endmodule

// File: rtl/zfifo_sync_ctrl.sv
// Synchronous FIFO control: pointers, count, status flags and the pop-valid strobe around zfifo_dualport.
module zfifo_sync_ctrl
  import zfifo_sync_ctrl_pkg::*;
#(
  parameter int depth      = 64,
  parameter int log2_depth = 6,
  parameter int width      = 8,
  parameter int afull_thr  = 48
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iPushEn,
  input  logic [width-1:0]    iPushData,
  input  logic                iPopEn,
  output logic [width-1:0]    oPopData,
  output logic                oPopValid,
  output logic                oFull,
  output logic                oEmpty,
  output logic                oAlmostFull,
  output logic [log2_depth:0] oCount,
  output logic                oOverflow,
  output logic                oUnderflow
);

  localparam int PW = ptrWidth(log2_depth);

  if (!depthOk(depth, log2_depth)) begin : gBadDepth
    $error("zfifo_sync_ctrl: depth must be a power of two >= 2 matching log2_depth");
  end

  logic [PW-1:0] wrPtr, rdPtr, cntNxt;
  logic          pushAcc, popAcc;

  // Acceptance uses only registered flags, so no input-to-flag combinational path exists.
  assign pushAcc = iPushEn & ~oFull;
  assign popAcc  = iPopEn  & ~oEmpty;
  assign cntNxt  = oCount + PW'(pushAcc) - PW'(popAcc);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      oCount      <= '0;
      oFull       <= 1'b0;
      oEmpty      <= 1'b1;
      oAlmostFull <= 1'b0;
      oPopValid   <= 1'b0;
      oOverflow   <= 1'b0;
      oUnderflow  <= 1'b0;
    end else begin
      if (pushAcc) wrPtr <= wrPtr + 1'b1;
      if (popAcc)  rdPtr <= rdPtr + 1'b1;
      oCount      <= cntNxt;
      oFull       <= (cntNxt == PW'(depth));
      oEmpty      <= (cntNxt == '0);
      oAlmostFull <= (cntNxt >= PW'(afull_thr));
      oPopValid   <= popAcc;
      oOverflow   <= oOverflow  | (iPushEn & oFull);
      oUnderflow  <= oUnderflow | (iPopEn  & oEmpty);
    end
  end

  zfifo_dualport #(
    .depth      (depth),
    .log2_depth (log2_depth),
    .width      (width)
  ) uRam (
    .iClk    (iClk),
    .iWrEn   (pushAcc),
    .iWrAddr (wrPtr[log2_depth-1:0]),
    .iWrData (iPushData),
    .iRdEn   (popAcc),
    .iRdAddr (rdPtr[log2_depth-1:0]),
    .oRdData (oPopData)
  );

endmodule

// File: tb/tb_zfifo_sync_ctrl.sv
// Scoreboard bench for zfifo_sync_ctrl at depth 4: directed pushes/pops, monitor checks popped words.
module tb_zfifo_sync_ctrl;

  localparam int DEPTH = 4;
  localparam int L2    = 2;
  localparam int W     = 8;
  localparam int AFT   = 3;

  logic         iClk = 1'b0;
  logic         iRst, iPushEn, iPopEn;
  logic [W-1:0] iPushData;
  logic [W-1:0] oPopData;
  logic         oPopValid, oFull, oEmpty, oAlmostFull, oOverflow, oUnderflow;
  logic [L2:0]  oCount;

  int nTests = 0;
  int nFail  = 0;
  logic [W-1:0] expQ[$];
  bit done = 1'b0;

  zfifo_sync_ctrl #(.depth(DEPTH), .log2_depth(L2), .width(W), .afull_thr(AFT)) dut (
    .iClk(iClk), .iRst(iRst), .iPushEn(iPushEn), .iPushData(iPushData), .iPopEn(iPopEn),
    .oPopData(oPopData), .oPopValid(oPopValid), .oFull(oFull), .oEmpty(oEmpty),
    .oAlmostFull(oAlmostFull), .oCount(oCount), .oOverflow(oOverflow), .oUnderflow(oUnderflow)
  );

  always #5 iClk = ~iClk;

  // Monitor: every pop strobe must match the oldest expected word.
  always @(negedge iClk) begin
    if (!done && oPopValid) begin
      logic [W-1:0] e;
      nTests++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("FAIL popdata: unexpected oPopValid, data=%h, none expected", oPopData);
      end else begin
        e = expQ.pop_front();
        if (oPopData !== e) begin
          nFail++;
          $display("FAIL popdata: got %h, expected %h", oPopData, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chkStat(input string tag, input int cnt, input bit emp, input bit ful,
                         input bit af, input bit ovf, input bit udf);
    chk({tag, ".count"}, 32'(oCount), 32'(cnt));
    chk({tag, ".empty"}, 32'(oEmpty), 32'(emp));
    chk({tag, ".full"},  32'(oFull),  32'(ful));
    chk({tag, ".afull"}, 32'(oAlmostFull), 32'(af));
    chk({tag, ".ovf"},   32'(oOverflow),  32'(ovf));
    chk({tag, ".udf"},   32'(oUnderflow), 32'(udf));
  endtask

  // One clock with the given inputs; returns 1 ns after the edge with inputs idle.
  task automatic cyc(input bit push, input logic [W-1:0] d, input bit pop, input bit rst = 1'b0);
    iPushEn = push; iPushData = d; iPopEn = pop; iRst = rst;
    @(posedge iClk); #1;
    iPushEn = 1'b0; iPopEn = 1'b0; iRst = 1'b0;
  endtask

  initial begin
    iRst = 1'b1; iPushEn = 1'b0; iPopEn = 1'b0; iPushData = '0;
    repeat (2) @(posedge iClk);
    #1;
    // 1: reset then idle
    cyc(0, 0, 0);
    chkStat("t1", 0, 1, 0, 0, 0, 0);
    chk("t1.popvalid", 32'(oPopValid), 0);

    // 2: fill, watch flags, drain in order
    cyc(1, 8'h11, 0); chkStat("t2.p1", 1, 0, 0, 0, 0, 0);
    cyc(1, 8'h22, 0); chkStat("t2.p2", 2, 0, 0, 0, 0, 0);
    cyc(1, 8'h33, 0); chkStat("t2.p3", 3, 0, 0, 1, 0, 0);
    cyc(1, 8'h44, 0); chkStat("t2.p4", 4, 0, 1, 1, 0, 0);
    expQ.push_back(8'h11); cyc(0, 0, 1);
    expQ.push_back(8'h22); cyc(0, 0, 1);
    expQ.push_back(8'h33); cyc(0, 0, 1);
    expQ.push_back(8'h44); cyc(0, 0, 1);
    chkStat("t2.end", 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0);

    // 3: overflow while full, rejected word must never appear
    for (int i = 1; i <= 4; i++) cyc(1, W'(i), 0);
    cyc(1, 8'h55, 0);
    chkStat("t3.ovf", 4, 0, 1, 1, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      expQ.push_back(W'(i)); cyc(0, 0, 1);
    end
    cyc(0, 0, 0);
    chkStat("t3.end", 0, 1, 0, 0, 1, 0);

    // 4: push+pop on empty: only push accepted
    cyc(1, 8'hA5, 1);
    chkStat("t4.udf", 1, 0, 0, 0, 1, 1);
    expQ.push_back(8'hA5); cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("t4.empty", 32'(oEmpty), 1);

    // 5: steady push+pop at count 2 across pointer wrap
    cyc(1, 8'd0, 0);
    cyc(1, 8'd1, 0);
    for (int i = 0; i < 10; i++) begin
      expQ.push_back(W'(i));
      cyc(1, W'(i + 2), 1);
      chk($sformatf("t5.count%0d", i), 32'(oCount), 2);
      chk($sformatf("t5.flags%0d", i), {30'b0, oFull, oEmpty}, 0);
    end
    expQ.push_back(8'd10); cyc(0, 0, 1);
    expQ.push_back(8'd11); cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("t5.empty", 32'(oEmpty), 1);

    // 6: reset coincident with a pop discards everything, no strobe
    cyc(1, 8'hC1, 0);
    cyc(1, 8'hC2, 0);
    cyc(1, 8'hC3, 0);
    cyc(0, 0, 1, 1);
    chkStat("t6.rst", 0, 1, 0, 0, 0, 0);
    chk("t6.popvalid", 32'(oPopValid), 0);
    cyc(1, 8'h77, 0);
    expQ.push_back(8'h77); cyc(0, 0, 1);
    cyc(0, 0, 0);
    chkStat("t6.end", 0, 1, 0, 0, 0, 0);

    repeat (2) @(posedge iClk);
    #1;
    done = 1'b1;
    chk("scoreboard.left", 32'(expQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
